// File: rtl/audio_udp_tx_scheduler.sv
// Round-robin scheduler feeding two audio byte caches into one UDP transmit engine.
// Each packet carries a 2-byte header {channel, sequence} followed by cache payload.
module audio_udp_tx_scheduler #(
    parameter int PKT_BYTES    = 256,
    parameter int LEVEL_W      = 12,
    parameter int FLUSH_CYCLES = 48000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [LEVEL_W-1:0] ch0_level,
    output logic               ch0_rd_en,
    input  logic [7:0]         ch0_rd_data,
    input  logic [LEVEL_W-1:0] ch1_level,
    output logic               ch1_rd_en,
    input  logic [7:0]         ch1_rd_data,
    output logic               udp_tx_start,
    output logic [15:0]        udp_tx_len,
    input  logic               udp_tx_req,
    output logic [7:0]         udp_tx_data,
    input  logic               udp_tx_done,
    output logic               busy,
    output logic               cur_ch
);

    localparam int CNT_W = $clog2(PKT_BYTES + 1);
    localparam int TMR_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [LEVEL_W-1:0] PKT_LVL = LEVEL_W'(PKT_BYTES);
    localparam logic [CNT_W-1:0]   PKT_CNT = CNT_W'(PKT_BYTES);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [TMR_W-1:0]   FL_MAX  = TMR_W'(FLUSH_CYCLES);
    localparam logic [TMR_W-1:0]   TMR_ONE = TMR_W'(1);
    localparam logic               FL_EN   = (FLUSH_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_START, S_HDR0, S_HDR1, S_PAYLOAD, S_WAIT
    } state_t;

    state_t r_state, w_next;

    logic [1:0][LEVEL_W-1:0] w_lvl;
    logic [1:0][TMR_W-1:0]   r_tmr;
    logic [1:0][7:0]         r_seq;
    logic [1:0]              w_full, w_part, w_elig;
    logic                    w_grant, w_rd, w_last, w_any;
    logic [CNT_W-1:0]        w_plen, r_plen, r_cnt;
    logic [15:0]             r_len;
    logic [7:0]              r_data, w_sel_data;
    logic                    r_cur, r_last, r_pend;

    assign w_lvl = {ch1_level, ch0_level};

    always_comb begin
        w_full = '0;
        w_part = '0;
        w_elig = '0;
        for (int c = 0; c < 2; c++) begin
            w_full[c] = (w_lvl[c] >= PKT_LVL);
            w_part[c] = (w_lvl[c] != '0) && !w_full[c];
            w_elig[c] = w_full[c] || (FL_EN && w_part[c] && (r_tmr[c] >= FL_MAX));
        end
    end

    // Both eligible: the channel not served last wins.
    assign w_any   = |w_elig;
    assign w_grant = (&w_elig) ? ~r_last : ~w_elig[0];
    assign w_plen  = w_full[w_grant] ? PKT_CNT : CNT_W'(w_lvl[w_grant]);
    assign w_last  = (r_cnt == (r_plen - CNT_ONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (en && w_any) w_next = S_ARB;
            S_ARB:     w_next = w_any ? S_START : S_IDLE;
            S_START:   w_next = S_HDR0;
            S_HDR0: begin
                if (udp_tx_done)     w_next = S_IDLE;
                else if (udp_tx_req) w_next = S_HDR1;
            end
            S_HDR1: begin
                if (udp_tx_done)     w_next = S_IDLE;
                else if (udp_tx_req) w_next = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (udp_tx_done)               w_next = S_IDLE;
                else if (udp_tx_req && w_last) w_next = S_WAIT;
            end
            S_WAIT:    if (udp_tx_done) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        udp_tx_start = (r_state == S_START);
        busy         = (r_state != S_IDLE);
        w_rd         = (r_state == S_PAYLOAD) && udp_tx_req;
        ch0_rd_en    = w_rd && !r_cur;
        ch1_rd_en    = w_rd && r_cur;
    end

    assign w_sel_data  = r_cur ? ch1_rd_data : ch0_rd_data;
    assign udp_tx_data = r_pend ? w_sel_data : r_data;
    assign udp_tx_len  = r_len;
    assign cur_ch      = r_cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur  <= 1'b0;
            r_last <= 1'b1;
            r_plen <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
            r_seq  <= '0;
            r_data <= '0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_rd;
            if (r_state == S_ARB && w_any) begin
                r_cur  <= w_grant;
                r_plen <= w_plen;
                r_len  <= 16'(w_plen) + 16'd2;
                r_cnt  <= '0;
            end
            if (w_rd) r_cnt <= r_cnt + CNT_ONE;
            if (r_state != S_IDLE && w_next == S_IDLE) r_len <= '0;
            if (r_state == S_WAIT && udp_tx_done) begin
                r_seq[r_cur] <= r_seq[r_cur] + 8'd1;
                r_last       <= r_cur;
            end
            if (udp_tx_req && r_state == S_HDR0)      r_data <= {7'b0, r_cur};
            else if (udp_tx_req && r_state == S_HDR1) r_data <= r_seq[r_cur];
            else if (udp_tx_req && !w_rd)             r_data <= 8'h00;
            else if (r_pend)                          r_data <= w_sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (r_state == S_WAIT && udp_tx_done && r_cur == 1'(c))
                    r_tmr[c] <= '0;
                else if (!w_part[c])
                    r_tmr[c] <= '0;
                else if (r_tmr[c] != '1)
                    r_tmr[c] <= r_tmr[c] + TMR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_audio_udp_tx_scheduler.sv
// Bench for audio_udp_tx_scheduler: cache models, a request-driving transmitter
// and a packet-level reference model (round robin, sequence numbers, payload order).
module tb_audio_udp_tx_scheduler;

    localparam int PKT = 256;
    localparam int FL  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [11:0] ch0_level = '0;
    logic [11:0] ch1_level = '0;
    logic        ch0_rd_en, ch1_rd_en;
    logic [7:0]  ch0_rd_data = '0;
    logic [7:0]  ch1_rd_data = '0;
    logic        udp_tx_start;
    logic [15:0] udp_tx_len;
    logic        udp_tx_req = 1'b0;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_done = 1'b0;
    logic        busy, cur_ch;

    int checks = 0;
    int fails  = 0;

    logic [7:0] mem0 [4096];
    logic [7:0] mem1 [4096];
    int p0 = 0, p1 = 0, rd0_cnt = 0, rd1_cnt = 0;

    int seq_m [2];
    int last_m;

    always #5 clk = ~clk;

    audio_udp_tx_scheduler #(
        .PKT_BYTES(PKT), .LEVEL_W(12), .FLUSH_CYCLES(FL)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .ch0_level(ch0_level), .ch0_rd_en(ch0_rd_en), .ch0_rd_data(ch0_rd_data),
        .ch1_level(ch1_level), .ch1_rd_en(ch1_rd_en), .ch1_rd_data(ch1_rd_data),
        .udp_tx_start(udp_tx_start), .udp_tx_len(udp_tx_len),
        .udp_tx_req(udp_tx_req), .udp_tx_data(udp_tx_data),
        .udp_tx_done(udp_tx_done), .busy(busy), .cur_ch(cur_ch)
    );

    // Cache models: byte streams with 1-cycle read latency.
    always @(posedge clk) begin
        if (ch0_rd_en) begin
            ch0_rd_data <= mem0[p0 % 4096];
            p0 <= p0 + 1;
            rd0_cnt <= rd0_cnt + 1;
        end
        if (ch1_rd_en) begin
            ch1_rd_data <= mem1[p1 % 4096];
            p1 <= p1 + 1;
            rd1_cnt <= rd1_cnt + 1;
        end
    end

    function automatic int grant(input bit e0, input bit e1);
        if (e0 && e1) return 1 - last_m;
        return e0 ? 0 : 1;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        udp_tx_req = 1'b0;
        udp_tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        seq_m[0] = 0;
        seq_m[1] = 0;
        last_m = 1;
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (udp_tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_pkt(input string nm, input int ech, input int plen,
                           input int nreq, input bit gaps, input bit en_off,
                           input int l0_after, input int l1_after);
        bit seen;
        int base, c0, c1, exp_rd;
        logic [7:0] exp_b, got;
        wait_start(seen);
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL %s start_timeout: no udp_tx_start within 400 cycles", nm);
            return;
        end
        if (en_off) en = 1'b0;
        checks++;
        if (udp_tx_len !== 16'(plen + 2)) begin
            fails++;
            $display("FAIL %s len: got %0d want %0d", nm, udp_tx_len, plen + 2);
        end
        checks++;
        if (cur_ch !== 1'(ech) || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s grant: cur_ch=%0d busy=%0d want ch %0d busy 1",
                     nm, cur_ch, busy, ech);
        end
        base = ech ? p1 : p0;
        c0 = rd0_cnt;
        c1 = rd1_cnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < nreq; i++) begin
            udp_tx_req = 1'b1;
            @(posedge clk);
            #1;
            if (i == 0)             exp_b = 8'(ech);
            else if (i == 1)        exp_b = 8'(seq_m[ech]);
            else if (i - 2 < plen)  exp_b = ech ? mem1[(base + i - 2) % 4096]
                                                : mem0[(base + i - 2) % 4096];
            else                    exp_b = 8'h00;
            got = udp_tx_data;
            checks++;
            if (got !== exp_b) begin
                fails++;
                $display("FAIL %s byte%0d: got %02h want %02h", nm, i, got, exp_b);
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                udp_tx_req = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
                checks++;
                if (udp_tx_data !== got) begin
                    fails++;
                    $display("FAIL %s hold%0d: got %02h want %02h",
                             nm, i, udp_tx_data, got);
                end
            end
        end
        udp_tx_req = 1'b0;
        exp_rd = (nreq - 2 < 0) ? 0 : ((nreq - 2 > plen) ? plen : nreq - 2);
        checks++;
        if ((ech ? rd1_cnt - c1 : rd0_cnt - c0) != exp_rd ||
            (ech ? rd0_cnt - c0 : rd1_cnt - c1) != 0) begin
            fails++;
            $display("FAIL %s rd_count: ch0 %0d ch1 %0d want %0d on ch%0d only",
                     nm, rd0_cnt - c0, rd1_cnt - c1, exp_rd, ech);
        end
        checks++;
        if (busy !== 1'b1 || udp_tx_start !== 1'b0) begin
            fails++;
            $display("FAIL %s wait_done: busy=%0d start=%0d want 1/0",
                     nm, busy, udp_tx_start);
        end
        ch0_level = 12'(l0_after);
        ch1_level = 12'(l1_after);
        udp_tx_done = 1'b1;
        @(posedge clk);
        #1;
        udp_tx_done = 1'b0;
        seq_m[ech] = (seq_m[ech] + 1) % 256;
        last_m = ech;
        checks++;
        if (busy !== 1'b0 || udp_tx_len !== 16'd0) begin
            fails++;
            $display("FAIL %s end: busy=%0d len=%0d want 0/0", nm, busy, udp_tx_len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if ({udp_tx_start, udp_tx_len, udp_tx_data, ch0_rd_en, ch1_rd_en, busy, cur_ch}
            !== 29'd0) begin
            fails++;
            $display("FAIL reset_outputs: start=%0d len=%0d data=%02h rd=%0d%0d busy=%0d ch=%0d want all 0",
                     udp_tx_start, udp_tx_len, udp_tx_data, ch0_rd_en, ch1_rd_en, busy, cur_ch);
        end
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || udp_tx_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%0d start=%0d want 0/0", busy, udp_tx_start);
        end
    endtask

    task automatic test_single();
        do_reset();
        en = 1'b1;
        ch0_level = 12'd300;
        ch1_level = 12'd0;
        run_pkt("single", grant(1, 0), PKT, PKT + 2, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_alternate();
        int ech;
        do_reset();
        en = 1'b1;
        ch0_level = 12'd512;
        ch1_level = 12'd512;
        for (int k = 0; k < 4; k++) begin
            ech = grant(1, 1);
            run_pkt("alternate", ech, PKT, PKT + 2, 1'b1, 1'b0,
                    (k == 3) ? 0 : 512, (k == 3) ? 0 : 512);
        end
    endtask

    task automatic test_flush();
        int early = 0;
        do_reset();
        en = 1'b1;
        ch0_level = 12'd0;
        ch1_level = 12'd10;
        for (int i = 0; i < FL; i++) begin
            @(posedge clk);
            #1;
            if (udp_tx_start === 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            fails++;
            $display("FAIL flush_early: %0d starts before %0d cycles, want 0", early, FL);
        end
        run_pkt("flush", grant(0, 1), 10, 12, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_overrun();
        ch0_level = 12'd300;
        ch1_level = 12'd0;
        run_pkt("overrun", grant(1, 0), PKT, 300, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_abort();
        bit seen;
        ch0_level = 12'd512;
        ch1_level = 12'd0;
        wait_start(seen);
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL abort_start: no udp_tx_start within 400 cycles");
            return;
        end
        @(posedge clk);
        #1;
        udp_tx_req = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        udp_tx_req = 1'b0;
        udp_tx_done = 1'b1;
        @(posedge clk);
        #1;
        udp_tx_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: busy=%0d want 0", busy);
        end
        run_pkt("after_abort", grant(1, 0), PKT, PKT + 2, 1'b0, 1'b0, 512, 0);
    endtask

    task automatic test_en_mid();
        int starts = 0;
        run_pkt("en_mid", grant(1, 0), PKT, PKT + 2, 1'b0, 1'b1, 512, 0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (udp_tx_start === 1'b1 || busy === 1'b1) starts++;
        end
        checks++;
        if (starts != 0) begin
            fails++;
            $display("FAIL en_off_idle: %0d active cycles with en low, want 0", starts);
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        en = 1'b1;
        ch0_level = 12'd512;
        ch1_level = 12'd512;
        run_pkt("pre_rst", grant(1, 1), PKT, PKT + 2, 1'b0, 1'b0, 512, 512);
        wait_start(seen);
        checks++;
        if (!seen || cur_ch !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_start: seen=%0d cur_ch=%0d want 1/1", seen, cur_ch);
        end
        @(posedge clk);
        #1;
        udp_tx_req = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (ch1_rd_en !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_reading: ch1_rd_en=%0d want 1", ch1_rd_en);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({udp_tx_start, udp_tx_len, udp_tx_data, ch0_rd_en, ch1_rd_en, busy, cur_ch}
            !== 29'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs: start=%0d len=%0d data=%02h rd=%0d%0d busy=%0d ch=%0d want all 0",
                     udp_tx_start, udp_tx_len, udp_tx_data, ch0_rd_en, ch1_rd_en, busy, cur_ch);
        end
        udp_tx_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        seq_m[0] = 0;
        seq_m[1] = 0;
        last_m = 1;
        run_pkt("post_rst", grant(1, 1), PKT, PKT + 2, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_seq_wrap();
        do_reset();
        en = 1'b1;
        ch0_level = 12'd512;
        ch1_level = 12'd0;
        for (int k = 0; k < 257; k++)
            run_pkt("seq_wrap", grant(1, 0), PKT, PKT + 2, 1'b0, 1'b0,
                    (k == 256) ? 0 : 512, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
        end
        seq_m[0] = 0;
        seq_m[1] = 0;
        last_m = 1;
        test_reset();
        test_single();
        test_alternate();
        test_flush();
        test_overrun();
        test_abort();
        test_en_mid();
        test_reset_mid();
        test_seq_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/audio_udp_tx_scheduler.md
Name: audio_udp_tx_scheduler

Overview:
- Shares one UDP transmit engine between two audio byte-stream caches: channel 0 (left) and channel 1 (right).
- Each cache exposes a fill level and a 1-cycle-latency read port.
- The scheduler picks a channel round-robin and starts a UDP packet.
- It then streams a 2-byte header followed by that channel's payload bytes on the transmitter's byte requests.
- It sits between the voice cache stage and the ethernet UDP core.

Parameters:
- PKT_BYTES, 256, full payload size in bytes (1..1024).
- LEVEL_W, 12, width of cache fill-level inputs.
- FLUSH_CYCLES, 48000, idle cycles before a partial (non-empty, below PKT_BYTES) cache is sent; 0 disables flushing.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- en  in  1  scheduling enable
- ch0_level  in  LEVEL_W  bytes held in channel 0 cache
- ch0_rd_en  out  1  channel 0 read strobe
- ch0_rd_data  in  8  channel 0 byte, valid the cycle after ch0_rd_en
- ch1_level  in  LEVEL_W  bytes held in channel 1 cache
- ch1_rd_en  out  1  channel 1 read strobe
- ch1_rd_data  in  8  channel 1 byte, valid the cycle after ch1_rd_en
- udp_tx_start  out  1  one-cycle packet start pulse
- udp_tx_len  out  16  packet length in bytes (payload + 2)
- udp_tx_req  in  1  transmitter byte request
- udp_tx_data  out  8  byte answering a request, valid the cycle after udp_tx_req
- udp_tx_done  in  1  transmitter finished current packet
- busy  out  1  high outside IDLE
- cur_ch  out  1  channel owning the current packet

Behaviour:
- Reset (rst=0, async): state IDLE, outputs all 0, both sequence counters 0, both flush timers 0, round-robin pointer favours ch0.
- States: IDLE -> ARB -> START -> HDR0 -> HDR1 -> PAYLOAD -> WAIT_DONE -> IDLE.
- Eligibility of channel c: level_c >= PKT_BYTES, or (level_c != 0 and flush_timer_c >= FLUSH_CYCLES and FLUSH_CYCLES != 0).
- Flush timer c: increments (saturating) each cycle while 0 < level_c < PKT_BYTES. It clears when level_c == 0, when level_c >= PKT_BYTES, or when c is served.
- IDLE: if en and at least one channel is eligible, go to ARB.
- ARB (1 cycle):
  - If both channels are eligible, grant the channel not served last.
  - If only one is eligible, grant it.
  - If neither is eligible (levels changed), return to IDLE.
  - Latch cur_ch, payload_len = min(level, PKT_BYTES), udp_tx_len = payload_len + 2.
- START: udp_tx_start=1 for exactly one cycle, then HDR0. udp_tx_len holds its value from START until leaving WAIT_DONE.
- Header and payload sequencing, one byte per udp_tx_req, data appearing the next cycle:
  - First request: data {7'b0, cur_ch}.
  - Second request: data seq[cur_ch].
  - Subsequent requests: the selected chX_rd_en is driven combinationally equal to udp_tx_req. udp_tx_data is muxed from the selected chX_rd_data in the following cycle.
  - The non-selected rd_en is always 0.
- Requests are counted. After payload_len payload reads, go to WAIT_DONE. Further requests return 0x00 and issue no rd_en (never underflow a cache).
- udp_tx_data holds its last value when there is no request.
- WAIT_DONE: on udp_tx_done, seq[cur_ch] increments (8-bit, 255 -> 0), round-robin pointer records cur_ch, flush_timer[cur_ch] clears, go to IDLE.
- udp_tx_done arriving early (before the header or payload is complete) aborts to IDLE with no seq increment. Bytes already read are lost.
- en deasserted mid-packet: the current packet completes, then the block stays in IDLE.
- udp_tx_start is never issued while busy.

Test Plan:
- ch0_level=300, ch1_level=0, PKT_BYTES=256 -> one start, udp_tx_len=258, bytes 0x00, 0x00, then 256 ch0 bytes in order, exactly 256 ch0_rd_en pulses, ch1_rd_en never high.
- Both levels=512, udp_tx_done after each packet -> packets alternate ch0, ch1, ch0, ch1; second ch0 header byte1 = 0x01.
- ch1_level held at 10, FLUSH_CYCLES=100 -> no start before cycle 100; then udp_tx_len=12 and exactly 10 ch1 reads.
- 300 requests against a 258-byte packet -> last 42 responses are 0x00 with no rd_en; state reaches WAIT_DONE.
- 256 packets on ch0 -> header byte1 runs 0x00..0xFF, then 0x00 on packet 257.
- rst pulled low mid-PAYLOAD -> all outputs 0 immediately, seq counters 0, next grant goes to ch0.
